// File: rtl/pc_predict_gen_pkg.sv
// Shared widths, constants and 2-bit branch counter encodings for the fetch PC
// predictor.
package pc_predict_gen_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  function automatic ctr_t ctr_inc(input ctr_t c);
    case (c)
      CTR_SNT: return CTR_WNT;
      CTR_WNT: return CTR_WT;
      default: return CTR_ST;
    endcase
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    case (c)
      CTR_ST:  return CTR_WT;
      CTR_WT:  return CTR_WNT;
      default: return CTR_SNT;
    endcase
  endfunction

  function automatic logic ctr_taken(input ctr_t c);
    return c[1];
  endfunction

endpackage

// File: rtl/pc_predict_gen_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous
// update/allocate, valid bits cleared on reset.
module pc_btb
  import pc_predict_gen_pkg::*;
#(
  parameter int unsigned XLEN        = ADDR_WIDTH,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter logic [1:0]  CTR_INIT    = 2'b01
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic [XLEN-1:0] lookup_target,
  input  logic            upd_enable,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  ctr_t                   ctr_q    [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] upd_tag;
  logic             lk_hit;
  logic             upd_hit;
  logic             unused_low_bits;

  assign lk_idx  = lookup_pc[IDX_W+1:2];
  assign lk_tag  = lookup_pc[XLEN-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDX_W+2];
  assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  always_comb begin
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lookup_taken  = lk_hit && ctr_taken(ctr_q[lk_idx]);
    lookup_target = lk_hit ? target_q[lk_idx] : '0;
    upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        ctr_q[i] <= ctr_t'(CTR_INIT);
      end
    end else if (rdy_in && upd_enable) begin
      if (upd_hit) begin
        if (upd_taken) begin
          ctr_q[upd_idx]    <= ctr_inc(ctr_q[upd_idx]);
          target_q[upd_idx] <= upd_target;
        end else begin
          ctr_q[upd_idx] <= ctr_dec(ctr_q[upd_idx]);
        end
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= TRUE;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/pc_predict_gen.sv
// Fetch PC register with ROB redirect and BTB-driven next-PC selection.
module pc_predict_gen
  import pc_predict_gen_pkg::*;
#(
  parameter int unsigned     XLEN        = ADDR_WIDTH,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter logic [1:0]      CTR_INIT    = 2'b01
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            rob2pc_enable,
  input  logic [XLEN-1:0] rob2pc_pc,
  input  logic            fetch2pc_enable,
  output logic [XLEN-1:0] pc2fetch_next_pc,
  output logic            pc2fetch_pred_taken,
  output logic [XLEN-1:0] pc2fetch_pred_target,
  input  logic            rob2pc_upd_enable,
  input  logic [XLEN-1:0] rob2pc_upd_pc,
  input  logic            rob2pc_upd_taken,
  input  logic [XLEN-1:0] rob2pc_upd_target
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  pc_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES),
    .CTR_INIT    (CTR_INIT)
  ) u_btb (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .lookup_pc     (pc_q),
    .lookup_taken  (pc2fetch_pred_taken),
    .lookup_target (pc2fetch_pred_target),
    .upd_enable    (rob2pc_upd_enable),
    .upd_pc        (rob2pc_upd_pc),
    .upd_taken     (rob2pc_upd_taken),
    .upd_target    (rob2pc_upd_target)
  );

  assign pc2fetch_next_pc = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (rob2pc_enable) begin
      pc_d = rob2pc_pc;
    end else if (fetch2pc_enable) begin
      pc_d = pc2fetch_pred_taken ? pc2fetch_pred_target : pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q <= RESET_PC;
    end else if (rdy_in) begin
      pc_q <= pc_d;
    end
  end

endmodule
